// File: rtl/ariane_pkg.sv
`default_nettype none
// =====================================================================
// Package  : ariane_pkg
// Brief    : Shared types, constants and helpers for the perceptron
//            branch predictor training path.
// Revision : 1.0 - initial release
// =====================================================================
package ariane_pkg;

  localparam int unsigned VLEN               = 64;
  localparam int unsigned PBP_DEF_THETA      = 33;
  localparam int unsigned PBP_DEF_WEIGHT_W   = 8;
  localparam int unsigned PBP_DEF_GHR_LENGTH = 10;
  localparam int unsigned PBP_DEF_Y_W        = 12;

  // One resolved conditional branch as delivered by execute
  typedef struct packed {
    logic [VLEN-1:0]               pc;
    logic                          taken;
    logic                          pred_taken;
    logic [PBP_DEF_GHR_LENGTH-1:0] ghr;
    logic [PBP_DEF_Y_W-1:0]        y;
  } pbp_resolve_t;

  // Packed weight vector, w0 (bias) in the least significant slot
  typedef logic [(PBP_DEF_GHR_LENGTH+1)*PBP_DEF_WEIGHT_W-1:0] pbp_weights_t;

  // Add +1 (up) or -1 to a signed weight of wbits bits, clamping to its range
  function automatic int pbp_sat_add(input int w, input logic up, input int unsigned wbits);
    int sum;
    int hi;
    int lo;
    sum = up ? (w + 1) : (w - 1);
    hi  = (1 << (wbits - 1)) - 1;
    lo  = -(1 << (wbits - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

  // Half-word granular index: drop bit 0 so compressed PCs stay distinct
  function automatic logic [VLEN-1:0] pbp_index(input logic [VLEN-1:0] pc);
    return pc >> 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pbp_resolve_fifo.sv
`default_nettype none
// =====================================================================
// Module   : pbp_resolve_fifo
// Brief    : DEPTH-entry FIFO of resolved branches. Pointers carry one
//            extra wrap bit to tell full from empty.
// Revision : 1.0 - initial release
// =====================================================================
module pbp_resolve_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = pbp_resolve_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  T               mem_q [DEPTH];
  T               mem_d [DEPTH];

  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next pointer/storage state; push into a full queue and pop of an empty one are ignored
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Pointer registers, cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, no reset needed since pointers gate visibility
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/pbp_trainer.sv
`default_nettype none
// =====================================================================
// Module   : pbp_trainer
// Brief    : Buffers resolved branches and, when training is needed,
//            performs a serialized read-modify-write of the PC's
//            perceptron weight vector with saturating arithmetic.
// Revision : 1.0 - initial release
// =====================================================================
module pbp_trainer
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned GHR_LENGTH = PBP_DEF_GHR_LENGTH,
  parameter int unsigned WEIGHT_W   = PBP_DEF_WEIGHT_W,
  parameter int unsigned Y_W        = PBP_DEF_Y_W,
  parameter int unsigned THETA      = PBP_DEF_THETA,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 debug_mode_i,
  input  logic                                 res_valid_i,
  output logic                                 res_ready_o,
  input  logic [VLEN-1:0]                      res_pc_i,
  input  logic                                 res_taken_i,
  input  logic                                 res_pred_taken_i,
  input  logic [GHR_LENGTH-1:0]                res_ghr_i,
  input  logic [Y_W-1:0]                       res_y_i,
  output logic                                 tbl_rd_en_o,
  output logic [$clog2(NR_ENTRIES)-1:0]        tbl_rd_idx_o,
  input  logic [(GHR_LENGTH+1)*WEIGHT_W-1:0]   tbl_rd_data_i,
  output logic                                 tbl_wr_en_o,
  output logic [$clog2(NR_ENTRIES)-1:0]        tbl_wr_idx_o,
  output logic [(GHR_LENGTH+1)*WEIGHT_W-1:0]   tbl_wr_data_o,
  output logic                                 busy_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam int unsigned NW    = GHR_LENGTH + 1;
  localparam int unsigned DW    = NW * WEIGHT_W;
  localparam logic [Y_W:0] THETA_Y = (Y_W+1)'(THETA);

  typedef struct packed {
    logic [VLEN-1:0]       pc;
    logic                  taken;
    logic                  pred_taken;
    logic [GHR_LENGTH-1:0] ghr;
    logic [Y_W-1:0]        y;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  taken_q, taken_d;
  logic [GHR_LENGTH-1:0] ghr_q, ghr_d;
  logic [DW-1:0]         wdata_q, wdata_d;

  entry_t           push_data;
  entry_t           head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head_idx;
  logic [Y_W:0]     y_ext;
  logic [Y_W:0]     y_abs;
  logic             need_train;
  logic [DW-1:0]    new_w;

  assign push_data = '{pc: res_pc_i, taken: res_taken_i, pred_taken: res_pred_taken_i,
                       ghr: res_ghr_i, y: res_y_i};
  // Debug mode keeps ready visible but silently drops the resolution
  assign push        = res_valid_i && !full && !debug_mode_i;
  assign res_ready_o = !full;

  pbp_resolve_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // |y| is taken one bit wider so the most negative y does not wrap to itself
  assign head_idx   = IDX_W'(pbp_index(head.pc));
  assign y_ext      = {head.y[Y_W-1], head.y};
  assign y_abs      = y_ext[Y_W] ? (~y_ext + {{Y_W{1'b0}}, 1'b1}) : y_ext;
  assign need_train = (head.taken != head.pred_taken) || (y_abs <= THETA_Y);

  // Saturating +/-1 update of every weight read back from the table
  always_comb begin
    new_w = '0;
    new_w[WEIGHT_W-1:0] = WEIGHT_W'(pbp_sat_add(
        int'($signed(tbl_rd_data_i[WEIGHT_W-1:0])), taken_q, WEIGHT_W));
    for (int i = 1; i < NW; i++) begin
      new_w[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(pbp_sat_add(
          int'($signed(tbl_rd_data_i[i*WEIGHT_W +: WEIGHT_W])),
          ghr_q[i-1] == taken_q, WEIGHT_W));
    end
  end

  // Training FSM: pop/examine in IDLE, compute in UPDATE, write back in WRITE
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    taken_d       = taken_q;
    ghr_d         = ghr_q;
    wdata_d       = wdata_q;
    pop           = 1'b0;
    tbl_rd_en_o   = 1'b0;
    tbl_rd_idx_o  = '0;
    tbl_wr_en_o   = 1'b0;
    tbl_wr_idx_o  = '0;
    tbl_wr_data_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (need_train) begin
            idx_d        = head_idx;
            taken_d      = head.taken;
            ghr_d        = head.ghr;
            tbl_rd_en_o  = 1'b1;
            tbl_rd_idx_o = head_idx;
            state_d      = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        wdata_d = new_w;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        tbl_wr_en_o   = 1'b1;
        tbl_wr_idx_o  = idx_q;
        tbl_wr_data_o = wdata_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and latched-entry registers; reset abandons any in-flight update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      taken_q <= 1'b0;
      ghr_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      taken_q <= taken_d;
      ghr_q   <= ghr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o = !empty || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pbp_trainer.sv
`default_nettype none
// =====================================================================
// Module   : tb_pbp_trainer
// Brief    : Directed self-checking bench for pbp_trainer.
// Revision : 1.0 - initial release
// =====================================================================
module tb_pbp_trainer;
  import ariane_pkg::*;

  localparam int NW = 11;
  localparam int DW = 88;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            debug_mode_i;
  logic            res_valid_i;
  logic            res_ready_o;
  logic [VLEN-1:0] res_pc_i;
  logic            res_taken_i;
  logic            res_pred_taken_i;
  logic [9:0]      res_ghr_i;
  logic [11:0]     res_y_i;
  logic            tbl_rd_en_o;
  logic [9:0]      tbl_rd_idx_o;
  logic [DW-1:0]   tbl_rd_data_i;
  logic            tbl_wr_en_o;
  logic [9:0]      tbl_wr_idx_o;
  logic [DW-1:0]   tbl_wr_data_o;
  logic            busy_o;

  pbp_trainer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .debug_mode_i     (debug_mode_i),
    .res_valid_i      (res_valid_i),
    .res_ready_o      (res_ready_o),
    .res_pc_i         (res_pc_i),
    .res_taken_i      (res_taken_i),
    .res_pred_taken_i (res_pred_taken_i),
    .res_ghr_i        (res_ghr_i),
    .res_y_i          (res_y_i),
    .tbl_rd_en_o      (tbl_rd_en_o),
    .tbl_rd_idx_o     (tbl_rd_idx_o),
    .tbl_rd_data_i    (tbl_rd_data_i),
    .tbl_wr_en_o      (tbl_wr_en_o),
    .tbl_wr_idx_o     (tbl_wr_idx_o),
    .tbl_wr_data_o    (tbl_wr_data_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Weight table model: one-cycle read latency, writes land at the edge
  logic [DW-1:0] mem [1024];
  logic          pre_en = 1'b0;
  logic [9:0]    pre_idx = '0;
  logic [7:0]    pre_val = '0;
  always @(posedge clk_i) begin
    if (tbl_wr_en_o) mem[tbl_wr_idx_o] <= tbl_wr_data_o;
    else if (pre_en) mem[pre_idx] <= {NW{pre_val}};
    tbl_rd_data_i <= tbl_rd_en_o ? mem[tbl_rd_idx_o] : '0;
  end

  typedef struct {
    int            cyc;
    logic [9:0]    idx;
    logic [DW-1:0] data;
  } ev_t;
  ev_t rd_log[$];
  ev_t wr_log[$];

  always @(negedge clk_i) begin
    if (tbl_rd_en_o) rd_log.push_back('{cyc, tbl_rd_idx_o, '0});
    if (tbl_wr_en_o) wr_log.push_back('{cyc, tbl_wr_idx_o, tbl_wr_data_o});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [7:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    tick();
    pre_en  = 1'b0;
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] w0, input logic [7:0] wone,
                                        input logic [7:0] wzero, input logic [9:0] ghr);
    logic [DW-1:0] r;
    r[7:0] = w0;
    for (int i = 1; i < NW; i++) r[i*8 +: 8] = ghr[i-1] ? wone : wzero;
    return r;
  endfunction

  task automatic drive(input logic [VLEN-1:0] pc, input logic t, input logic p,
                       input logic [9:0] ghr, input logic [11:0] y);
    res_pc_i         = pc;
    res_taken_i      = t;
    res_pred_taken_i = p;
    res_ghr_i        = ghr;
    res_y_i          = y;
    res_valid_i      = 1'b1;
  endtask

  typedef struct {
    string           name;
    logic [VLEN-1:0] pc;
    logic            taken;
    logic            pred;
    logic [9:0]      ghr;
    logic [11:0]     y;
    logic [7:0]      init;
    logic            train;
    logic [9:0]      idx;
    logic [7:0]      w0;
    logic [7:0]      wone;
    logic [7:0]      wzero;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input vec_t v);
    int c0;
    preload(v.idx, v.init);
    rd_log.delete();
    wr_log.delete();
    drive(v.pc, v.taken, v.pred, v.ghr, v.y);
    c0 = cyc;
    tick();
    res_valid_i = 1'b0;
    tick();
    chk({v.name, " busy@+2"}, DW'(busy_o), DW'(v.train));
    repeat (4) tick();
    chk({v.name, " reads"}, DW'(rd_log.size()), DW'(v.train));
    if (v.train) begin
      if (rd_log.size() > 0) begin
        chk({v.name, " rd_cyc"}, DW'(rd_log[0].cyc), DW'(c0 + 1));
        chk({v.name, " rd_idx"}, DW'(rd_log[0].idx), DW'(v.idx));
      end
      chk({v.name, " writes"}, DW'(wr_log.size()), DW'(1));
      if (wr_log.size() > 0) begin
        chk({v.name, " wr_cyc"}, DW'(wr_log[0].cyc), DW'(c0 + 3));
        chk({v.name, " wr_idx"}, DW'(wr_log[0].idx), DW'(v.idx));
        chk({v.name, " wr_data"}, wr_log[0].data, mk(v.w0, v.wone, v.wzero, v.ghr));
      end
    end else begin
      chk({v.name, " writes"}, DW'(wr_log.size()), DW'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int k;
    int n;
    bit exp_rdy [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};

    //            name        pc                taken pred ghr            y       init   train idx     w0     wone   wzero
    vecs[0]  = '{"mispred",  64'h8000_0010,    1'b1, 1'b0, 10'b0000000001, 12'd100, 8'h00, 1'b1, 10'h008, 8'h01, 8'h01, 8'hFF};
    vecs[1]  = '{"y40",      64'h8000_0040,    1'b1, 1'b1, 10'h000,        12'd40,  8'h00, 1'b0, 10'h020, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{"y33",      64'h8000_0124,    1'b0, 1'b0, 10'b1010101010, 12'd33,  8'h05, 1'b1, 10'h092, 8'h04, 8'h04, 8'h06};
    vecs[3]  = '{"yneg33",   64'h0000_2002,    1'b0, 1'b0, 10'h000,        12'hFDF, 8'hFD, 1'b1, 10'h001, 8'hFC, 8'h00, 8'hFE};
    vecs[4]  = '{"y34",      64'h0000_0100,    1'b1, 1'b1, 10'h000,        12'h022, 8'h00, 1'b0, 10'h080, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{"yneg34",   64'h0000_0104,    1'b0, 1'b0, 10'h000,        12'hFDE, 8'h00, 1'b0, 10'h082, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{"ymin",     64'h0000_0108,    1'b1, 1'b1, 10'h000,        12'h800, 8'h00, 1'b0, 10'h084, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{"sat_pos",  64'h0000_0200,    1'b1, 1'b1, 10'h3FF,        12'h000, 8'h7F, 1'b1, 10'h100, 8'h7F, 8'h7F, 8'h7F};
    vecs[8]  = '{"sat_neg",  64'h0000_0204,    1'b0, 1'b0, 10'h3FF,        12'h000, 8'h80, 1'b1, 10'h102, 8'h80, 8'h80, 8'h80};
    vecs[9]  = '{"sat_mix",  64'h0000_0208,    1'b0, 1'b0, 10'h000,        12'h000, 8'h7F, 1'b1, 10'h104, 8'h7E, 8'h00, 8'h7F};
    vecs[10] = '{"rvc_pc",   64'h8000_0012,    1'b0, 1'b1, 10'b1100000000, 12'h1F4, 8'h00, 1'b1, 10'h009, 8'hFF, 8'hFF, 8'h01};
    vecs[11] = '{"pc_alias", 64'h8000_0802,    1'b1, 1'b0, 10'b0101010101, 12'h7FF, 8'h10, 1'b1, 10'h001, 8'h11, 8'h11, 8'h0F};
    vecs[12] = '{"yneg1",    64'h0000_0300,    1'b1, 1'b1, 10'b0000011111, 12'hFFF, 8'h80, 1'b1, 10'h180, 8'h81, 8'h81, 8'h80};

    rst_i = 1'b1;
    debug_mode_i = 1'b0;
    res_valid_i = 1'b0;
    res_pc_i = '0;
    res_taken_i = 1'b0;
    res_pred_taken_i = 1'b0;
    res_ghr_i = '0;
    res_y_i = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    chk("rst ready", DW'(res_ready_o), DW'(1));
    chk("rst busy", DW'(busy_o), DW'(0));
    chk("rst rd_en", DW'(tbl_rd_en_o), DW'(0));
    chk("rst rd_idx", DW'(tbl_rd_idx_o), DW'(0));
    chk("rst wr_en", DW'(tbl_wr_en_o), DW'(0));
    chk("rst wr_idx", DW'(tbl_wr_idx_o), DW'(0));
    chk("rst wr_data", tbl_wr_data_o, DW'(0));

    // Single-entry vectors
    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Back-to-back trainings on the same index see each other's writes
    preload(10'h005, 8'h00);
    rd_log.delete();
    wr_log.delete();
    c0 = cyc;
    for (int j = 0; j < 4; j++) begin
      drive(64'h0000_000A, 1'b1, 1'b0, 10'h000, 12'h000);
      chk($sformatf("b2b ready%0d", j), DW'(res_ready_o), DW'(1));
      tick();
    end
    res_valid_i = 1'b0;
    repeat (8) tick();
    chk("b2b busy@last_wr", DW'(busy_o), DW'(1));
    chk("b2b wr_en@last_wr", DW'(tbl_wr_en_o), DW'(1));
    tick();
    chk("b2b busy_fall", DW'(busy_o), DW'(0));
    chk("b2b writes", DW'(wr_log.size()), DW'(4));
    for (int j = 0; j < 4 && j < wr_log.size(); j++) begin
      chk($sformatf("b2b wr_cyc%0d", j), DW'(wr_log[j].cyc), DW'(c0 + 3 + 3 * j));
      chk($sformatf("b2b wr_data%0d", j), wr_log[j].data,
          mk(8'(j + 1), 8'h00, 8'(-(j + 1)), 10'h000));
    end

    // Queue full with valid held: no enqueue while full, even on a pop cycle
    rd_log.delete();
    wr_log.delete();
    k = 0;
    for (int j = 0; j < 9; j++) begin
      if (k < 7) drive(64'h40 + 64'(2 * k), 1'b1, 1'b0, 10'h000, 12'h000);
      else res_valid_i = 1'b0;
      chk($sformatf("full ready@%0d", j), DW'(res_ready_o), DW'(exp_rdy[j]));
      if (res_ready_o && res_valid_i) k++;
      tick();
    end
    res_valid_i = 1'b0;
    chk("full accepted", DW'(k), DW'(7));
    n = 0;
    while (busy_o && n < 80) begin
      tick();
      n++;
    end
    chk("full drain", DW'(busy_o), DW'(0));
    chk("full writes", DW'(wr_log.size()), DW'(7));
    for (int j = 0; j < wr_log.size() && j < 7; j++)
      chk($sformatf("full wr_idx%0d", j), DW'(wr_log[j].idx), DW'(10'h020 + 10'(j)));

    // Debug mode drops resolutions while ready stays up
    rd_log.delete();
    wr_log.delete();
    debug_mode_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(64'h0000_0600 + 64'(2 * j), 1'b1, 1'b0, 10'h000, 12'h000);
      chk($sformatf("dbg ready%0d", j), DW'(res_ready_o), DW'(1));
      tick();
    end
    res_valid_i = 1'b0;
    debug_mode_i = 1'b0;
    repeat (5) tick();
    chk("dbg reads", DW'(rd_log.size()), DW'(0));
    chk("dbg busy", DW'(busy_o), DW'(0));

    // Reset during UPDATE abandons the write
    preload(10'h0F0, 8'h00);
    rd_log.delete();
    wr_log.delete();
    drive(64'h0000_01E0, 1'b1, 1'b0, 10'h000, 12'h000);
    tick();
    res_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (5) tick();
    chk("rstmid reads", DW'(rd_log.size()), DW'(1));
    chk("rstmid writes", DW'(wr_log.size()), DW'(0));
    chk("rstmid busy", DW'(busy_o), DW'(0));
    chk("rstmid ready", DW'(res_ready_o), DW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pbp_trainer.md
Name: pbp_trainer

Overview:
Training stage downstream of the perceptron predictor. Accepts resolved conditional branches from execute, buffers them, and decides per branch whether the weights need training: on a mispredict, or when |y| <= THETA. When training is needed it performs a serialized read-modify-write of that PC's weight vector through a dedicated table port, with saturating signed arithmetic. Sits between branch resolution and the predictor's weight storage.

Parameters:
NR_ENTRIES, 1024, perceptron table entries (power of 2)
GHR_LENGTH, 10, history bits per perceptron; weights per entry = GHR_LENGTH+1
WEIGHT_W, 8, signed weight width
Y_W, 12, signed width of the perceptron output y
THETA, 33, training threshold, floor(1.93*GHR_LENGTH+14)
DEPTH, 4, resolve queue depth (power of 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
debug_mode_i  in  1  suppresses enqueue of new resolutions
res_valid_i  in  1  resolved branch valid
res_ready_o  out  1  queue can accept an entry
res_pc_i  in  riscv::VLEN  branch PC
res_taken_i  in  1  actual outcome
res_pred_taken_i  in  1  predicted outcome
res_ghr_i  in  GHR_LENGTH  history snapshot used for the prediction
res_y_i  in  Y_W  signed perceptron output used for the prediction
tbl_rd_en_o  out  1  weight read request
tbl_rd_idx_o  out  $clog2(NR_ENTRIES)  read index
tbl_rd_data_i  in  (GHR_LENGTH+1)*WEIGHT_W  weights; valid the cycle after tbl_rd_en_o
tbl_wr_en_o  out  1  weight write
tbl_wr_idx_o  out  $clog2(NR_ENTRIES)  write index
tbl_wr_data_o  out  (GHR_LENGTH+1)*WEIGHT_W  updated weights
busy_o  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset: queue emptied, FSM to IDLE; all outputs 0 except res_ready_o=1 (from the cycle after reset).
- Enqueue when res_valid_i & res_ready_o & !debug_mode_i. With debug_mode_i=1, res_ready_o is still driven and entries are silently dropped.
- res_ready_o = !full. There is no enqueue-into-full bypass, even when a dequeue happens in the same cycle.
- Index = res_pc_i[$clog2(NR_ENTRIES):1], so compressed-aligned PCs map distinctly.
- Need-train = (res_taken_i != res_pred_taken_i) | (|y| <= THETA).
  - |y| is computed in Y_W+1 bits, so y = -2^(Y_W-1) is handled correctly.
- FSM:
  - IDLE: if the queue is non-empty, examine its head.
    - If need-train is false: pop the entry, stay in IDLE. This costs 1 cycle and no table access.
    - Otherwise: pop the entry, latch it, assert tbl_rd_en_o/tbl_rd_idx_o this cycle, go to UPDATE.
  - UPDATE: tbl_rd_data_i is valid. Compute the new weights into a register, go to WRITE.
  - WRITE: tbl_wr_en_o=1 with the latched index and data for exactly 1 cycle, go to IDLE.
  - Trained branch occupancy: 3 cycles. The next read is issued no earlier than the cycle after the write.
- Weight update, with t = +1 if taken else -1:
  - w0 (bias) += t.
  - wi (i = 1..GHR_LENGTH) += t if ghr[i-1] == 1, else -= t.
  - All weights saturate to [-2^(WEIGHT_W-1), 2^(WEIGHT_W-1)-1]; no wrap.
- Weight packing: w0 in bits [WEIGHT_W-1:0], wi at [i*WEIGHT_W +: WEIGHT_W].
- Flush and debug do not abort an in-flight RMW. rst_i mid-RMW returns to IDLE with no write issued.
- The table guarantees write-before-read ordering across cycles. Back-to-back entries to the same index therefore see the updated weights.
- Pointer wrap: pointers are $clog2(DEPTH)+1 bits wide, with MSB distinguishing full from empty.

Decomposition:
- Package ariane_pkg:
  - pbp_resolve_t (pc, taken, pred_taken, ghr, y).
  - Weight-vector typedef.
  - Functions pbp_sat_add and pbp_index.
  - Constants for default THETA and WEIGHT_W.
- One sub-module: pbp_resolve_fifo, a generic DEPTH-entry FIFO of pbp_resolve_t providing full/empty/push/pop.

Test Plan:
- Mispredict: pc=0x80000010, weights all 0, ghr=10'b0000000001, taken=1, pred=0 -> tbl_rd_en_o in the cycle after enqueue, with idx 0x008. Two cycles later, write with w0=+1, w1=+1, w2..w10=-1.
- Correct prediction, y=40 -> entry popped, no tbl_rd_en_o/tbl_wr_en_o. Correct prediction, y=33 and y=-33 -> trains.
- Saturation: read weights all +127, taken=1, ghr=all ones -> writes all +127. Read all -128, taken=0, ghr=all ones -> w0..w10 stay -128.
- Back-to-back: 4 enqueues (all training) in consecutive cycles -> res_ready_o=1 throughout; each write occurs 3 cycles after the previous; busy_o falls after the last write.
- Queue full: hold res_valid_i while 5 training entries are presented -> entry 5 not accepted until the first pop. debug_mode_i=1 during enqueue -> nothing trained.
- Reset mid-UPDATE: rst_i=1 for 1 cycle -> no tbl_wr_en_o, busy_o=0, res_ready_o=1 afterwards.
